mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between the multicycle CPU controller and one I/O requester
//  (VGA/UART/debug loader). CPU sources are instruction fetch, load and store.
//  Registered grant with single-beat accesses and fixed read latency; starvation guard protects the I/O side.
//  Sits between the controller/datapath memory-address mux and the block-RAM memory.
// PARAMETERS
//  WIDTH       16  data width of memory words
//  ADDR_WIDTH  16  memory address width
//  READ_LAT    1   cycles from ACC cycle to mem_rdata valid (1..3)
//  STARVE_MAX  4   consecutive CPU wins over a waiting I/O request before I/O is forced (1..15)
// PORTS
//  clk        in  1           rising-edge clock
//  reset      in  1           asynchronous, active-low reset
//  cpu_req    in  1           CPU access request; held with cpu_we/addr/wdata until cpu_gnt
//  cpu_we     in  1           1 = write, 0 = read
//  cpu_addr   in  ADDR_WIDTH  CPU address
//  cpu_wdata  in  WIDTH       CPU write data
//  cpu_gnt    out 1           one-cycle pulse: CPU access is on the memory port this cycle
//  cpu_rvalid out 1           one-cycle pulse: cpu_rdata holds read result
//  cpu_rdata  out WIDTH       registered read data; held until next CPU read completes
//  io_req/io_we/io_addr/io_wdata/io_gnt/io_rvalid/io_rdata  same as cpu_* for the I/O requester
//  mem_addr   out ADDR_WIDTH  memory address (registered)
//  mem_wdata  out WIDTH       memory write data (registered)
//  mem_we     out 1           memory write strobe, high only in a write ACC cycle
//  mem_rdata  in  WIDTH       memory read data, valid READ_LAT cycles after ACC
// BEHAVIOUR
//  Reset (reset==0, any time): state=IDLE, starve count=0, all outputs 0 incl. rdata regs; in-flight read dropped, no rvalid.
//  FSM: IDLE -> ACC_CPU | ACC_IO -> (write) IDLE | (read) RD_WAIT -> IDLE.
//  IDLE: samples requests at posedge. Winner's addr/wdata/we are registered onto mem_*; gnt pulses in the ACC cycle.
//  Arbitration: only one req -> that one. Both -> CPU, unless starve count == STARVE_MAX -> IO.
//  Starve counter: +1 when CPU wins while io_req=1 (saturates at STARVE_MAX); cleared on any IO grant.
//  ACC write: mem_we=1 for exactly that cycle; next state IDLE. mem_we never asserts in any other state.
//  ACC read: RD_WAIT counts READ_LAT-1 further cycles. Then mem_rdata is captured into owner's rdata.
//   Owner's rvalid pulses on the cycle after capture. Next state IDLE.
//  Every transaction returns through IDLE, so a requester that drops req after seeing gnt is never double-granted.
//   Max throughput: one write per 2 cycles, one read per READ_LAT+2 cycles.
//  Requests that arrive during ACC/RD_WAIT are ignored until IDLE; requester must hold req + payload stable until gnt.
//  mem_addr/mem_wdata hold last values outside ACC; the non-owner's rdata/rvalid are untouched.
//  gnt for both requesters is never high in the same cycle; at most one transaction is in flight.
// CONFIGURATION
//  MEM_ARB_LOCK_EN defined: adds input cpu_lock (1). If cpu_lock=1 while a CPU access is granted:
//   arbiter ignores io_req, starve count frozen, until an IDLE cycle with cpu_lock=0.
//   Used for read-modify-write sequences.
//  MEM_ARB_LOCK_EN undefined: no cpu_lock port, no locking; behaviour exactly as above.
// STRUCTURE
//  mem_arb_pkg: state encoding (IDLE, ACC_CPU, ACC_IO, RD_WAIT), owner constants (OWN_CPU=0, OWN_IO=1),
//   read-latency counter width function.
//  Sub-module mem_arb_starve_ctr: saturating counter (inc/clr/freeze, hit flag), width $clog2(STARVE_MAX+1).
//  Top holds FSM, owner reg, latency counter, mem_* and rdata/rvalid registers.
// TESTING
//  1 CPU read, addr 0x0010, mem[0x10]=0xBEEF, READ_LAT=1: cpu_gnt @T+1, cpu_rvalid @T+3 with cpu_rdata=0xBEEF; io_* quiet.
//  2 IO write 0x0020<=0x1234: io_gnt and mem_we=1 for one cycle, mem_addr=0x0020, mem_wdata=0x1234; readback via CPU = 0x1234.
//  3 Both req continuously, STARVE_MAX=4, all writes: grant order CPU,CPU,CPU,CPU,IO,CPU... ; gnts never overlap.
//  4 Reset low during RD_WAIT with READ_LAT=3: all outputs 0 next edge, no rvalid after release; next IDLE grants afresh.
//  5 Requests raised mid-transaction: io_req rises in ACC_CPU; IO not granted before IDLE, granted first cycle after.
//  6 With MEM_ARB_LOCK_EN, cpu_lock=1 over CPU read+write to 0x0030: io_req held high gets no grant until lock drops; then io_gnt next ACC.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//  Shared definitions for the memory-port arbiter slice:
//   - arb_state_e : arbiter FSM state encoding (IDLE, ACC_CPU, ACC_IO, RD_WAIT)
//   - OWN_CPU / OWN_IO : owner encoding of the in-flight transaction
//   - rd_cnt_width() : width of the read-latency down-counter for a given READ_LAT
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACC_CPU = 2'd1,
        ACC_IO  = 2'd2,
        RD_WAIT = 2'd3
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_IO  = 1'b1;

    // The counter only has to hold READ_LAT-1, so it never needs more than
    // $clog2(READ_LAT) bits; keep at least one bit so the vector is legal.
    function automatic int rd_cnt_width(input int read_lat);
        return (read_lat > 2) ? $clog2(read_lat) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//  Bundles the CPU requester, I/O requester and block-RAM signals of the arbiter.
//  Modports:
//   slave  : arbiter view (requests and mem_rdata in; grants, read data, mem_* out)
//   master : environment view (requesters and memory)
//  cpu_req/cpu_we/cpu_addr/cpu_wdata, io_* : requests, held until the matching gnt
//  cpu_gnt/io_gnt     : one-cycle pulse in the ACC cycle of that requester
//  cpu_rvalid/io_rvalid, cpu_rdata/io_rdata : read completion and held read data
//  mem_addr/mem_wdata/mem_we : registered memory command, mem_rdata : memory read data
//  cpu_lock : present only when MEM_ARB_LOCK_EN is defined
interface mem_port_arbiter_if #(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0]      cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [WIDTH-1:0]      cpu_rdata;

    logic                  io_req;
    logic                  io_we;
    logic [ADDR_WIDTH-1:0] io_addr;
    logic [WIDTH-1:0]      io_wdata;
    logic                  io_gnt;
    logic                  io_rvalid;
    logic [WIDTH-1:0]      io_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic                  mem_we;
    logic [WIDTH-1:0]      mem_rdata;

`ifdef MEM_ARB_LOCK_EN
    logic                  cpu_lock;
`endif

    modport slave (
`ifdef MEM_ARB_LOCK_EN
        input  cpu_lock,
`endif
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  io_req, io_we, io_addr, io_wdata,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output io_gnt, io_rvalid, io_rdata,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
`ifdef MEM_ARB_LOCK_EN
        output cpu_lock,
`endif
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output io_req, io_we, io_addr, io_wdata,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  io_gnt, io_rvalid, io_rdata,
        input  mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr
//  Saturating count of consecutive CPU wins over a waiting I/O request.
//  Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset (count -> 0)
//   inc    : CPU won while I/O was requesting (saturates at STARVE_MAX)
//   clr    : I/O was granted
//   freeze : hold the count unchanged (CPU lock active)
//   hit    : count has reached STARVE_MAX, I/O must win the next contest
module mem_arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    input  logic freeze,
    output logic hit
);
    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (!freeze) begin
            if (clr) begin
                count_next = '0;
            end else if (inc && (count_reg != CW'(STARVE_MAX))) begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign hit = (count_reg == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//  Shares one block-RAM port between the multicycle CPU and one I/O requester.
//  Each access is IDLE -> ACC_CPU|ACC_IO -> (write) IDLE | (read) RD_WAIT -> IDLE,
//  so a requester that drops req after gnt is never granted twice.
//  Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset; clears state, starve count and all outputs
//   bus   : mem_port_arbiter_if.slave (requests, grants, read data, memory port)
//  Parameters: WIDTH, ADDR_WIDTH, READ_LAT (1..3), STARVE_MAX (1..15)
//  Optional: MEM_ARB_LOCK_EN adds bus.cpu_lock; a CPU access granted with cpu_lock=1
//   keeps I/O out (starve count frozen) until an IDLE cycle sees cpu_lock=0.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int LW = rd_cnt_width(READ_LAT);

    arb_state_e            state_reg, state_next;
    logic [LW-1:0]         lat_reg, lat_next;
    logic                  owner_reg;
    logic                  cpu_gnt_reg, io_gnt_reg;
    logic                  cpu_rvalid_reg, io_rvalid_reg;
    logic [WIDTH-1:0]      cpu_rdata_reg, io_rdata_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [WIDTH-1:0]      mem_wdata_reg;
    logic                  mem_we_reg;

    logic locked;
    logic io_eff;
    logic cpu_take;
    logic io_take;
    logic starve_hit;
    logic rd_done;

`ifdef MEM_ARB_LOCK_EN
    logic lock_reg;

    // Lock is taken when a CPU access is granted with cpu_lock high and is held
    // through every IDLE cycle that still sees cpu_lock high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            lock_reg <= bus.cpu_lock && (cpu_take || lock_reg);
        end
    end

    // An IDLE cycle with cpu_lock low arbitrates normally in that same cycle.
    assign locked = lock_reg && bus.cpu_lock;
`else
    assign locked = 1'b0;
`endif

    // Arbitration happens only in IDLE; io_req is invisible while locked.
    assign io_eff   = bus.io_req && !locked;
    assign io_take  = (state_reg == IDLE) && io_eff && (!bus.cpu_req || starve_hit);
    assign cpu_take = (state_reg == IDLE) && bus.cpu_req && !io_take;
    assign rd_done  = (state_reg == RD_WAIT) && (lat_reg == '0);

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .reset  (reset),
        .inc    (cpu_take && io_eff),
        .clr    (io_take),
        .freeze (locked),
        .hit    (starve_hit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            lat_reg   <= '0;
        end else begin
            state_reg <= state_next;
            lat_reg   <= lat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        lat_next   = lat_reg;
        case (state_reg)
            IDLE: begin
                if (cpu_take) begin
                    state_next = ACC_CPU;
                end else if (io_take) begin
                    state_next = ACC_IO;
                end
            end
            ACC_CPU, ACC_IO: begin
                // mem_we_reg carries the granted access type during ACC.
                if (mem_we_reg) begin
                    state_next = IDLE;
                end else begin
                    state_next = RD_WAIT;
                    lat_next   = LW'(READ_LAT - 1);
                end
            end
            RD_WAIT: begin
                if (lat_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    lat_next = lat_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg      <= OWN_CPU;
            cpu_gnt_reg    <= 1'b0;
            io_gnt_reg     <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            io_rvalid_reg  <= 1'b0;
            cpu_rdata_reg  <= '0;
            io_rdata_reg   <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_we_reg     <= 1'b0;
        end else begin
            cpu_gnt_reg    <= cpu_take;
            io_gnt_reg     <= io_take;
            cpu_rvalid_reg <= 1'b0;
            io_rvalid_reg  <= 1'b0;
            mem_we_reg     <= 1'b0;
            if (cpu_take) begin
                owner_reg     <= OWN_CPU;
                mem_addr_reg  <= bus.cpu_addr;
                mem_wdata_reg <= bus.cpu_wdata;
                mem_we_reg    <= bus.cpu_we;
            end else if (io_take) begin
                owner_reg     <= OWN_IO;
                mem_addr_reg  <= bus.io_addr;
                mem_wdata_reg <= bus.io_wdata;
                mem_we_reg    <= bus.io_we;
            end
            if (rd_done) begin
                if (owner_reg == OWN_CPU) begin
                    cpu_rdata_reg  <= bus.mem_rdata;
                    cpu_rvalid_reg <= 1'b1;
                end else begin
                    io_rdata_reg   <= bus.mem_rdata;
                    io_rvalid_reg  <= 1'b1;
                end
            end
        end
    end

    assign bus.cpu_gnt    = cpu_gnt_reg;
    assign bus.io_gnt     = io_gnt_reg;
    assign bus.cpu_rvalid = cpu_rvalid_reg;
    assign bus.io_rvalid  = io_rvalid_reg;
    assign bus.cpu_rdata  = cpu_rdata_reg;
    assign bus.io_rdata   = io_rdata_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_wdata  = mem_wdata_reg;
    assign bus.mem_we     = mem_we_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//  Drives mem_port_arbiter (READ_LAT=1) against a small block-RAM model with a
//  read-data scoreboard, plus a READ_LAT=3 instance for the reset-during-read case.
//  The cpu_lock sequence is included when MEM_ARB_LOCK_EN is defined.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int W  = 16;
    localparam int AW = 16;

    logic clk;
    logic reset;
    logic reset3;

    mem_port_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus  ();
    mem_port_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW)) bus3 ();

    mem_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .READ_LAT(1), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mem_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .READ_LAT(3), .STARVE_MAX(4)) dut_lat3 (
        .clk   (clk),
        .reset (reset3),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Block RAM for the READ_LAT=1 instance: one registered read stage.
    logic [W-1:0] tmem [0:255];
    logic [W-1:0] rd_q;
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) tmem[i] <= (i == 16) ? 16'hBEEF : 16'h0000;
        end else if (bus.mem_we) begin
            tmem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
        rd_q <= tmem[bus.mem_addr[7:0]];
    end
    assign bus.mem_rdata = rd_q;

    // READ_LAT=3 memory: data = addr ^ 5A5A, valid only exactly 3 cycles after ACC.
    logic [W-1:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= (bus3.cpu_gnt || bus3.io_gnt) ? (bus3.mem_addr ^ 16'h5A5A) : 16'h0000;
        p2 <= p1;
        p3 <= p2;
    end
    assign bus3.mem_rdata = p3;

    // Scoreboard: expected read data pushed at request time, popped on rvalid.
    logic [W-1:0] cpu_q [$];
    logic [W-1:0] io_q  [$];
    logic [W-1:0] mon_exp;

    always @(negedge clk) begin
        if (bus.cpu_rvalid) begin
            if (cpu_q.size() == 0) chk("cpu_rvalid_unexpected", 1, 0);
            else begin
                mon_exp = cpu_q.pop_front();
                chk("cpu_rdata", bus.cpu_rdata, mon_exp);
            end
        end
        if (bus.io_rvalid) begin
            if (io_q.size() == 0) chk("io_rvalid_unexpected", 1, 0);
            else begin
                mon_exp = io_q.pop_front();
                chk("io_rdata", bus.io_rdata, mon_exp);
            end
        end
        if (bus.cpu_gnt || bus.io_gnt) chk("gnt_overlap", bus.cpu_gnt & bus.io_gnt, 0);
        if (bus.mem_we) chk("mem_we_outside_acc", bus.cpu_gnt | bus.io_gnt, 1);
    end

    typedef struct packed {
        logic         io;
        logic         we;
        logic [AW-1:0] addr;
        logic [W-1:0]  wdata;
        logic [W-1:0]  rdata;
    } vec_t;

    vec_t tbl [8];

    task automatic wait_gnt(input logic io, input string name, output int n);
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (io ? bus.io_gnt : bus.cpu_gnt) break;
        end
        if (n > 20) chk(name, 0, 1);
    endtask

    // Called at a negedge; returns at the gnt negedge (write) or rvalid negedge (read).
    task automatic do_txn(input vec_t v, output int gw);
        int n;
        if (v.io) begin
            bus.io_req = 1'b1; bus.io_we = v.we; bus.io_addr = v.addr; bus.io_wdata = v.wdata;
            if (!v.we) io_q.push_back(v.rdata);
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
            if (!v.we) cpu_q.push_back(v.rdata);
        end
        wait_gnt(v.io, "tbl_gnt_timeout", gw);
        bus.io_req  = 1'b0;
        bus.cpu_req = 1'b0;
        chk("tbl_mem_addr", bus.mem_addr, v.addr);
        chk("tbl_mem_we", bus.mem_we, v.we);
        if (v.we) chk("tbl_mem_wdata", bus.mem_wdata, v.wdata);
        if (!v.we) begin
            for (n = 1; n <= 10; n++) begin
                @(negedge clk);
                if (v.io ? bus.io_rvalid : bus.cpu_rvalid) break;
            end
            chk("tbl_rvalid_latency", n, 2);
        end
    endtask

    task automatic rd3(input logic io, input logic [AW-1:0] addr);
        int n;
        if (io) begin bus3.io_req = 1'b1; bus3.io_we = 1'b0; bus3.io_addr = addr; end
        else    begin bus3.cpu_req = 1'b1; bus3.cpu_we = 1'b0; bus3.cpu_addr = addr; end
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (io ? bus3.io_gnt : bus3.cpu_gnt) break;
        end
        chk("lat3_gnt_latency", n, 1);
        bus3.io_req  = 1'b0;
        bus3.cpu_req = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (io ? bus3.io_rvalid : bus3.cpu_rvalid) break;
        end
        chk("lat3_rvalid_latency", n, 4);
        chk("lat3_rdata", io ? bus3.io_rdata : bus3.cpu_rdata, addr ^ 16'h5A5A);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gw;
        int k;
        logic rv_seen;

        tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        tbl[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        tbl[3] = '{1'b0, 1'b1, 16'h0040, 16'hCAFE, 16'h0000};
        tbl[4] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hCAFE};
        tbl[5] = '{1'b1, 1'b1, 16'h00FF, 16'h0001, 16'h0000};
        tbl[6] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h0001};
        tbl[7] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};

        reset = 1'b0; reset3 = 1'b0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.io_req = 0;  bus.io_we = 0;  bus.io_addr = 0;  bus.io_wdata = 0;
        bus3.cpu_req = 0; bus3.cpu_we = 0; bus3.cpu_addr = 0; bus3.cpu_wdata = 0;
        bus3.io_req = 0;  bus3.io_we = 0;  bus3.io_addr = 0;  bus3.io_wdata = 0;
`ifdef MEM_ARB_LOCK_EN
        bus.cpu_lock = 0;
        bus3.cpu_lock = 0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.cpu_gnt, bus.io_gnt, bus.cpu_rvalid, bus.io_rvalid, bus.cpu_rdata,
                              bus.io_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_we}, 0);
        reset = 1'b1; reset3 = 1'b1;
        @(negedge clk);

        // Table: single transactions; gnt is one cycle after request from IDLE,
        // two when the request is driven during a write's ACC cycle.
        for (int i = 0; i < 8; i++) begin
            do_txn(tbl[i], gw);
            chk("tbl_gnt_latency", gw, (i > 0 && tbl[i-1].we) ? 2 : 1);
        end

        // Both requesting writes continuously: I/O forced every fifth grant.
        bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 16'h0050; bus.cpu_wdata = 16'h1111;
        bus.io_req  = 1; bus.io_we  = 1; bus.io_addr  = 16'h0060; bus.io_wdata  = 16'h2222;
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            @(negedge clk);
            if (bus.cpu_gnt || bus.io_gnt) begin
                chk("starve_order_io", bus.io_gnt, (k % 5) == 4);
                k++;
            end
        end
        bus.cpu_req = 0; bus.io_req = 0;
        chk("starve_grant_count", k, 10);

        // io_req raised during ACC_CPU must wait for the next IDLE.
        @(negedge clk);
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0020;
        cpu_q.push_back(16'h1234);
        wait_gnt(1'b0, "mid_cpu_gnt_timeout", gw);
        bus.cpu_req = 0;
        bus.io_req = 1; bus.io_we = 1; bus.io_addr = 16'h0070; bus.io_wdata = 16'h7777;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk("mid_io_gnt", bus.io_gnt, c == 3);
        end
        bus.io_req = 0;
        chk("mid_io_mem_addr", bus.mem_addr, 16'h0070);
        @(negedge clk);

`ifdef MEM_ARB_LOCK_EN
        // Locked CPU read-modify-write keeps I/O out until the lock drops.
        bus.cpu_lock = 1;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 16'h0030;
        cpu_q.push_back(16'h0000);
        bus.io_req = 1; bus.io_we = 1; bus.io_addr = 16'h0031; bus.io_wdata = 16'h3131;
        wait_gnt(1'b0, "lock_rd_gnt_timeout", gw);
        bus.cpu_we = 1; bus.cpu_wdata = 16'hABCD;
        rv_seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            rv_seen = rv_seen | bus.io_gnt;
            if (bus.cpu_gnt) break;
        end
        chk("lock_wr_gnt_seen", bus.cpu_gnt, 1);
        chk("lock_io_blocked", rv_seen, 0);
        bus.cpu_req = 0; bus.cpu_lock = 0;
        wait_gnt(1'b1, "lock_io_gnt_timeout", gw);
        chk("lock_io_gnt_latency", gw, 2);
        bus.io_req = 0;
        @(negedge clk);
`endif

        // READ_LAT=3 instance: a full read, then reset during RD_WAIT.
        rd3(1'b1, 16'h0044);
        bus3.cpu_req = 1; bus3.cpu_we = 0; bus3.cpu_addr = 16'h0033;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus3.cpu_gnt) break;
        end
        chk("rst3_cpu_gnt_latency", k, 1);
        bus3.cpu_req = 0;
        @(negedge clk);
        reset3 = 1'b0;
        @(negedge clk);
        chk("rst3_outputs", {bus3.cpu_gnt, bus3.io_gnt, bus3.cpu_rvalid, bus3.io_rvalid, bus3.cpu_rdata,
                             bus3.io_rdata, bus3.mem_addr, bus3.mem_wdata, bus3.mem_we}, 0);
        reset3 = 1'b1;
        rv_seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rv_seen = rv_seen | bus3.cpu_rvalid | bus3.io_rvalid;
        end
        chk("rst3_no_rvalid", rv_seen, 0);
        rd3(1'b0, 16'h0055);

        repeat (2) @(negedge clk);
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("io_q_empty", io_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
